// File: rtl/dru_pkg.sv
// Shared encodings for the DRU load controller: command opcodes and FSM state encoding.
package dru_pkg;

    typedef logic [1:0] dru_op_t;

    localparam dru_op_t DRU_OP_CLR    = 2'b00;
    localparam dru_op_t DRU_OP_LD_MEM = 2'b01;
    localparam dru_op_t DRU_OP_LD_FB1 = 2'b10;
    localparam dru_op_t DRU_OP_LD_FB2 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_REQ_UP  = 3'd2,
        ST_RSP_UP  = 3'd3,
        ST_REQ_LO  = 3'd4,
        ST_RSP_LO  = 3'd5,
        ST_FB_WAIT = 3'd6,
        ST_DONE    = 3'd7
    } dru_state_e;

endpackage

// File: rtl/dru_load_ctrl_if.sv
// Signal bundle between the DRU load controller (master) and its command source,
// memory port, frame buffer and DRU (slave side).
interface dru_load_ctrl_if #(
    parameter int ADDR_W = 32
);
    import dru_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    dru_op_t           cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic              fb_valid;
    logic              clear_data_regs;
    logic              up_reg32_enable;
    logic              lo_reg32_enable;
    logic              reg64_enable1;
    logic              reg64_enable2;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, mem_gnt, mem_rvalid, fb_valid,
        output cmd_ready, mem_req, mem_addr, clear_data_regs,
               up_reg32_enable, lo_reg32_enable, reg64_enable1, reg64_enable2,
               done, err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, mem_gnt, mem_rvalid, fb_valid,
        input  cmd_ready, mem_req, mem_addr, clear_data_regs,
               up_reg32_enable, lo_reg32_enable, reg64_enable1, reg64_enable2,
               done, err
    );

endinterface

// File: rtl/dru_timeout_ctr.sv
// Wait-state watchdog: cleared by load, counts while enabled, flags expire on the
// LIMIT-th counted cycle. Used only when DRU_CTRL_TIMEOUT_EN is defined.
module dru_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int            CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/dru_load_ctrl.sv
// Command sequencer for the DRU: memory two-word load, frame-buffer 64-bit load and clear.
// Optional wait-state watchdog enabled by defining DRU_CTRL_TIMEOUT_EN.
module dru_load_ctrl
    import dru_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input logic              sys_clk,
    input logic              sys_rst,
    dru_load_ctrl_if.master  bus
);

    dru_state_e        state;
    logic [ADDR_W-1:0] addr;
    logic              fb_sel2;
    logic              cmd_ready_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              clear_r;
    logic              done_r;
    logic              progress;
    logic              timeout;

    always_comb begin
        progress = 1'b0;
        case (state)
            ST_REQ_UP, ST_REQ_LO: progress = bus.mem_gnt;
            ST_RSP_UP, ST_RSP_LO: progress = bus.mem_rvalid;
            ST_FB_WAIT:           progress = bus.fb_valid;
            default:              progress = 1'b0;
        endcase
    end

`ifdef DRU_CTRL_TIMEOUT_EN
    logic waiting;
    logic stay;
    logic expire;
    logic err_r;

    assign waiting = (state == ST_REQ_UP) || (state == ST_RSP_UP) || (state == ST_REQ_LO) ||
                     (state == ST_RSP_LO) || (state == ST_FB_WAIT);
    // Any state change (or idle) reloads the counter, so each wait state gets a fresh budget.
    assign stay    = waiting && !progress;

    dru_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .load   (!stay),
        .en     (stay),
        .expire (expire)
    );

    assign timeout = stay && expire;
    assign bus.err = err_r;
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= '0;
            clear_r     <= 1'b0;
            done_r      <= 1'b0;
`ifdef DRU_CTRL_TIMEOUT_EN
            err_r       <= 1'b0;
`endif
        end else begin
            clear_r <= 1'b0;
            done_r  <= 1'b0;
`ifdef DRU_CTRL_TIMEOUT_EN
            err_r   <= timeout;
`endif
            if (timeout) begin
                state     <= ST_DONE;
                mem_req_r <= 1'b0;
                done_r    <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.cmd_valid) begin
                            cmd_ready_r <= 1'b0;
                            case (bus.cmd_op)
                                DRU_OP_CLR: begin
                                    state   <= ST_CLR;
                                    clear_r <= 1'b1;
                                end
                                DRU_OP_LD_MEM: begin
                                    state      <= ST_REQ_UP;
                                    addr       <= bus.cmd_addr;
                                    mem_req_r  <= 1'b1;
                                    mem_addr_r <= bus.cmd_addr;
                                end
                                default: begin
                                    state   <= ST_FB_WAIT;
                                    fb_sel2 <= (bus.cmd_op == DRU_OP_LD_FB2);
                                end
                            endcase
                        end
                    end
                    ST_CLR: begin
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                    end
                    ST_REQ_UP: begin
                        if (bus.mem_gnt) begin
                            state     <= ST_RSP_UP;
                            mem_req_r <= 1'b0;
                        end
                    end
                    ST_RSP_UP: begin
                        if (bus.mem_rvalid) begin
                            state      <= ST_REQ_LO;
                            mem_req_r  <= 1'b1;
                            mem_addr_r <= addr + ADDR_W'(1);
                        end
                    end
                    ST_REQ_LO: begin
                        if (bus.mem_gnt) begin
                            state     <= ST_RSP_LO;
                            mem_req_r <= 1'b0;
                        end
                    end
                    ST_RSP_LO, ST_FB_WAIT: begin
                        if (progress) begin
                            state  <= ST_DONE;
                            done_r <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= ST_IDLE;
                        cmd_ready_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Enables are decoded from the state so the DRU sees at most one control per cycle.
    assign bus.up_reg32_enable = (state == ST_RSP_UP) && bus.mem_rvalid;
    assign bus.lo_reg32_enable = (state == ST_RSP_LO) && bus.mem_rvalid;
    assign bus.reg64_enable1   = (state == ST_FB_WAIT) && bus.fb_valid && !fb_sel2;
    assign bus.reg64_enable2   = (state == ST_FB_WAIT) && bus.fb_valid &&  fb_sel2;

    assign bus.cmd_ready       = cmd_ready_r;
    assign bus.mem_req         = mem_req_r;
    assign bus.mem_addr        = mem_addr_r;
    assign bus.clear_data_regs = clear_r;
    assign bus.done            = done_r;

endmodule
